atmr_sweep_ctrl: RTL
====================

# atmr_sweep_ctrl

Exhaustive-sweep controller for the ATMR benchmark triplets: ori/mai/men replicas plus VOTADOR voters. It walks every input vector through the triplet and classifies each response against the exact (ori) replica. It accumulates per-replica mismatch counts, voter-masking failures and voter-cell faults, and records the first vector the voted output gets wrong. It sits between the top-level test harness and a combinational ATMR instance, driving its `i_*` inputs and sampling its replica and `z*` outputs.

## Interface
Parameters:
- `N_IN`, default 7: replica input count; the sweep covers 2^N_IN vectors.
- `N_OUT`, default 10: replica output count (z0..z9).
- `CNT_W`, default 8: counter width; must be ≥ N_IN+1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a sweep; accepted only in IDLE.
- `busy`  out  1  high in SWEEP and DRAIN.
- `done`  out  1  one-cycle pulse when results are final.
- `vec_out`  out  N_IN  registered stimulus to the ATMR `i_*` inputs (bit k → `i_k_`).
- `ori_z`, `mai_z`, `men_z`  in  N_OUT each  replica outputs for `vec_out`.
- `vote_z`  in  N_OUT  voter outputs z0..z(N_OUT-1).
- `cnt_mai`  out  CNT_W  vectors where mai_z ≠ ori_z.
- `cnt_men`  out  CNT_W  vectors where men_z ≠ ori_z.
- `cnt_fail`  out  CNT_W  vectors where vote_z ≠ ori_z (masking failure).
- `cnt_vote_bad`  out  CNT_W  vectors where vote_z ≠ bitwise majority(ori,mai,men).
- `first_fail_vec`  out  N_IN  first vector counted in cnt_fail.
- `fail_valid`  out  1  first_fail_vec is meaningful.

## Operation
- FSM states: IDLE, SWEEP, DRAIN, DONE.
  - IDLE → SWEEP on `start`. In the same edge: clear all counters and `fail_valid`, set `first_fail_vec` to 0, set `vec_out` to 0.
  - SWEEP:
    - Each edge captures {ori_z, mai_z, men_z, vote_z, vec_out} into a compare stage register.
    - Then `vec_out` increments.
    - At `vec_out` = 2^N_IN−1 the capture still happens, `vec_out` returns to 0 (wrap) and the FSM moves to DRAIN.
  - DRAIN: the last captured vector is compared and counted. DRAIN → DONE.
  - DONE: `done` = 1 for exactly this cycle. DONE → IDLE unconditionally.
- Compare stage:
  - Each counter increments by at most 1 per vector. The condition is "any bit differs".
  - Counters saturate at 2^CNT_W−1. This cannot occur with legal parameters, but saturation is still implemented.
- First-fail capture: on the first vector with vote ≠ ori, latch the vector into `first_fail_vec` and set `fail_valid`. Later failures do not overwrite it.
- Holding and clearing of results:
  - Results hold after DONE until the next accepted `start`.
  - `start` in SWEEP, DRAIN or DONE is ignored. It is not queued.
- The DUT is purely combinational. Responses must be stable in the same cycle `vec_out` is presented.

## Timing
- Reset values: state IDLE; `busy` 0, `done` 0, `vec_out` 0; all counters 0; `first_fail_vec` 0; `fail_valid` 0.
- Reset mid-sweep aborts the sweep on the next edge. There is no `done` pulse and partial counts are discarded.
- `start` sampled high at edge 0:
  - `busy` = 1 and `vec_out` = 0 from cycle 1.
  - `vec_out` = k during cycle 1+k.
  - The last vector (2^N_IN−1) is presented in cycle 2^N_IN.
- DRAIN occurs in cycle 2^N_IN+1. For N_IN=7 this is cycle 129.
- `done` is high in cycle 2^N_IN+2 (cycle 130), with `busy` = 0 in that cycle.
- Result latency:
  - Counters for vector k are updated at the edge ending cycle 2+k.
  - Final values are visible in the `done` cycle.
- Throughput: one vector per cycle. A back-to-back `start` is accepted earliest in the cycle after `done`.
- `rst` takes priority over `start` in the same cycle.

## Test plan
- Identical replicas (mai = men = ori = vote = f(vec)), pulse `start` → `done` at cycle 130. All counters 0, `fail_valid` 0, `busy` high in cycles 1–129.
- mai_z bit 3 inverted for all vectors, vote = majority → `cnt_mai` = 128, `cnt_men` = 0, `cnt_fail` = 0, `cnt_vote_bad` = 0.
- mai and men both invert bit 0 only at vectors 5 and 9, vote = majority → `cnt_mai` = `cnt_men` = `cnt_fail` = 2, `first_fail_vec` = 5, `fail_valid` = 1.
- vote_z bit 9 forced to ~majority at vector 100 only → `cnt_vote_bad` = 1, `cnt_fail` = 1, `first_fail_vec` = 100.
- Assert `rst` at cycle 60 of a sweep with `cnt_mai` partially accumulated → next cycle state IDLE with all outputs at reset values and no `done`. A new `start` then yields full-run counts.
- Pulse `start` again at cycles 40 and 129 → ignored, single `done` at cycle 130. A `start` in cycle 131 begins a new sweep with counters cleared.

Source files
------------

// File: rtl/atmr_sweep_ctrl_if.sv
// Signal bundle between the ATMR sweep controller (slave) and the harness that
// owns the replica triplet and reads the results (master).
interface atmr_sweep_ctrl_if #(
  parameter int N_IN  = 7,
  parameter int N_OUT = 10,
  parameter int CNT_W = 8
);
  logic             i_start;
  logic             o_busy;
  logic             o_done;
  logic [N_IN-1:0]  o_vec_out;
  logic [N_OUT-1:0] i_ori_z;
  logic [N_OUT-1:0] i_mai_z;
  logic [N_OUT-1:0] i_men_z;
  logic [N_OUT-1:0] i_vote_z;
  logic [CNT_W-1:0] o_cnt_mai;
  logic [CNT_W-1:0] o_cnt_men;
  logic [CNT_W-1:0] o_cnt_fail;
  logic [CNT_W-1:0] o_cnt_vote_bad;
  logic [N_IN-1:0]  o_first_fail_vec;
  logic             o_fail_valid;

  modport master (
    output i_start, i_ori_z, i_mai_z, i_men_z, i_vote_z,
    input  o_busy, o_done, o_vec_out, o_cnt_mai, o_cnt_men, o_cnt_fail,
           o_cnt_vote_bad, o_first_fail_vec, o_fail_valid
  );

  modport slave (
    input  i_start, i_ori_z, i_mai_z, i_men_z, i_vote_z,
    output o_busy, o_done, o_vec_out, o_cnt_mai, o_cnt_men, o_cnt_fail,
           o_cnt_vote_bad, o_first_fail_vec, o_fail_valid
  );
endinterface

// File: rtl/atmr_sweep_ctrl.sv
// Exhaustive-sweep controller: walks every input vector through an ATMR triplet
// and tallies replica mismatches, masking failures and voter-cell faults.
module atmr_sweep_ctrl #(
  parameter int N_IN  = 7,
  parameter int N_OUT = 10,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  atmr_sweep_ctrl_if.slave  bus
);

  localparam logic [N_IN-1:0]  LAST_VEC = '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic             w_accept;

  logic [N_IN-1:0]  r_vec;
  logic [N_IN-1:0]  r_cmpVec;
  logic [N_OUT-1:0] r_cmpOri;
  logic [N_OUT-1:0] r_cmpMai;
  logic [N_OUT-1:0] r_cmpMen;
  logic [N_OUT-1:0] r_cmpVote;
  logic             r_cmpValid;

  logic [CNT_W-1:0] r_cntMai;
  logic [CNT_W-1:0] r_cntMen;
  logic [CNT_W-1:0] r_cntFail;
  logic [CNT_W-1:0] r_cntVoteBad;
  logic [N_IN-1:0]  r_firstFail;
  logic             r_failValid;

  logic [N_OUT-1:0] w_majority;
  logic             w_maiHit;
  logic             w_menHit;
  logic             w_failHit;
  logic             w_voteBadHit;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] cnt, input logic hit);
    return (hit && (cnt != CNT_MAX)) ? cnt + CNT_W'(1) : cnt;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.i_start) begin
          w_nextState = SWEEP;
          w_accept    = 1'b1;
        end
      end
      SWEEP:   if (r_vec == LAST_VEC) w_nextState = DRAIN;
      DRAIN:   w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Compare stage works on the vector captured one edge earlier.
  assign w_majority   = (r_cmpOri & r_cmpMai) | (r_cmpOri & r_cmpMen) | (r_cmpMai & r_cmpMen);
  assign w_maiHit     = (r_cmpMai  != r_cmpOri);
  assign w_menHit     = (r_cmpMen  != r_cmpOri);
  assign w_failHit    = (r_cmpVote != r_cmpOri);
  assign w_voteBadHit = (r_cmpVote != w_majority);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec        <= '0;
      r_cmpVec     <= '0;
      r_cmpOri     <= '0;
      r_cmpMai     <= '0;
      r_cmpMen     <= '0;
      r_cmpVote    <= '0;
      r_cmpValid   <= 1'b0;
      r_cntMai     <= '0;
      r_cntMen     <= '0;
      r_cntFail    <= '0;
      r_cntVoteBad <= '0;
      r_firstFail  <= '0;
      r_failValid  <= 1'b0;
    end else begin
      r_cmpValid <= 1'b0;
      if (w_accept) begin
        r_vec        <= '0;
        r_cntMai     <= '0;
        r_cntMen     <= '0;
        r_cntFail    <= '0;
        r_cntVoteBad <= '0;
        r_firstFail  <= '0;
        r_failValid  <= 1'b0;
      end else if (r_state == SWEEP) begin
        r_cmpVec   <= r_vec;
        r_cmpOri   <= bus.i_ori_z;
        r_cmpMai   <= bus.i_mai_z;
        r_cmpMen   <= bus.i_men_z;
        r_cmpVote  <= bus.i_vote_z;
        r_cmpValid <= 1'b1;
        r_vec      <= (r_vec == LAST_VEC) ? '0 : r_vec + N_IN'(1);
      end
      // The stage is never valid in IDLE, so this cannot collide with the clear above.
      if (r_cmpValid) begin
        r_cntMai     <= satInc(r_cntMai, w_maiHit);
        r_cntMen     <= satInc(r_cntMen, w_menHit);
        r_cntFail    <= satInc(r_cntFail, w_failHit);
        r_cntVoteBad <= satInc(r_cntVoteBad, w_voteBadHit);
        if (w_failHit && !r_failValid) begin
          r_firstFail <= r_cmpVec;
          r_failValid <= 1'b1;
        end
      end
    end
  end

  assign bus.o_busy           = (r_state == SWEEP) || (r_state == DRAIN);
  assign bus.o_done           = (r_state == DONE);
  assign bus.o_vec_out        = r_vec;
  assign bus.o_cnt_mai        = r_cntMai;
  assign bus.o_cnt_men        = r_cntMen;
  assign bus.o_cnt_fail       = r_cntFail;
  assign bus.o_cnt_vote_bad   = r_cntVoteBad;
  assign bus.o_first_fail_vec = r_firstFail;
  assign bus.o_fail_valid     = r_failValid;

endmodule
